// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;
  localparam int XLEN        = 64;
  localparam int REGADDR_W   = 5;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_e;

  // Write-back control captured when a memory access is launched.
  typedef struct packed {
    logic [REGADDR_W-1:0] rd;
    logic                 regwrite;
    logic                 memtoreg;
  } wb_ctrl_t;
endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM stage and the memory.
interface mem_access_stage_if;
  import mem_stage_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_timeout_ctr.sv
// WAIT-cycle counter: cleared on load, counts while enabled, flags the last allowed cycle.
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             cnt <= '0;
    else if (load)          cnt <= '0;
    else if (en && !expire) cnt <= cnt + CW'(1);
  end

  assign expire = en && (cnt == LAST);
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores, stalls the front end until ack/timeout, drives MEM/WB.
// Optional MEM_ALIGN_CHECK_EN rejects non-8-byte-aligned accesses and adds misalign_err.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REGADDR_W-1:0] rd_in,
  input  logic                 regwrite_in,
  input  logic                 memtoreg_in,
  input  logic                 memread_in,
  input  logic                 memwrite_in,
  input  logic                 branch_in,
  input  logic                 zero_in,
  input  logic [XLEN-1:0]      result_in,
  input  logic [XLEN-1:0]      data_in,
  input  logic [XLEN-1:0]      pc_in,
  mem_access_stage_if.master   mem,
  output logic                 stall,
  output logic                 pcsrc,
  output logic [XLEN-1:0]      branch_target,
  output logic [REGADDR_W-1:0] wb_rd,
  output logic                 wb_regwrite,
  output logic                 wb_memtoreg,
  output logic [XLEN-1:0]      wb_result,
  output logic [XLEN-1:0]      wb_rdata,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                 misalign_err,
`endif
  output logic                 timeout_err
);
  mem_state_e      state;
  wb_ctrl_t        held;
  logic            req_q, we_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic            mem_op, start, expire, in_wait;

  assign mem_op  = memread_in | memwrite_in;
  assign in_wait = (state == WAIT);
`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = mem_op && (result_in[2:0] != 3'b000);
  assign start      = (state == IDLE) && mem_op && !misaligned;
`else
  assign start      = (state == IDLE) && mem_op;
`endif

  // Stall releases in the same cycle the access completes or gives up.
  assign stall = start || (in_wait && !mem.mem_ack && !expire);

  assign pcsrc         = branch_in & zero_in;
  assign branch_target = pc_in;

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk    (clk),
    .reset  (reset),
    .load   (start),
    .en     (in_wait),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      held        <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wb_rd       <= '0;
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_result   <= '0;
      wb_rdata    <= '0;
      timeout_err <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= WAIT;
            req_q       <= 1'b1;
            we_q        <= memwrite_in & ~memread_in;  // load wins if both set
            addr_q      <= result_in;
            wdata_q     <= data_in;
            held        <= wb_ctrl_t'{rd: rd_in, regwrite: regwrite_in, memtoreg: memtoreg_in};
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 1'b0;
          end
`ifdef MEM_ALIGN_CHECK_EN
          else if (misaligned) begin
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            misalign_err <= 1'b1;
          end
`endif
          else begin
            wb_rd       <= rd_in;
            wb_regwrite <= regwrite_in;
            wb_memtoreg <= memtoreg_in;
            wb_result   <= result_in;
          end
        end
        WAIT: begin
          if (mem.mem_ack) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            wb_rd       <= held.rd;
            wb_regwrite <= held.regwrite & ~we_q;
            wb_memtoreg <= held.memtoreg;
            wb_result   <= addr_q;
            if (!we_q) wb_rdata <= mem.mem_rdata;
          end else begin
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 1'b0;
            if (expire) begin
              state       <= IDLE;
              req_q       <= 1'b0;
              timeout_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes reference results, monitor checks on retire.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  localparam int TO = 16;

  typedef struct {
    logic [4:0]  rd;
    logic        rw, mtr, mr, mw, br, z, stray;
    logic [63:0] res, data, pc, ackd;
    int          d;   // WAIT cycle (1-based) carrying ack; 0 = never acked
  } op_t;

  typedef struct {
    logic [4:0]  rd;
    logic        rw, mtr, terr, merr, we, pcsrc;
    logic [63:0] result, rdata, addr, wdata, pc;
    int          stalls, reqs;
  } exp_t;

  logic clk = 1'b0, reset = 1'b0;
  logic [4:0]  rd_in;
  logic        regwrite_in, memtoreg_in, memread_in, memwrite_in, branch_in, zero_in;
  logic [63:0] result_in, data_in, pc_in;
  logic        stall, pcsrc;
  logic [63:0] branch_target;
  logic [4:0]  wb_rd;
  logic        wb_regwrite, wb_memtoreg, timeout_err;
  logic [63:0] wb_result, wb_rdata;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  mem_access_stage_if mem_bus();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rd_in(rd_in), .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
    .memread_in(memread_in), .memwrite_in(memwrite_in),
    .branch_in(branch_in), .zero_in(zero_in),
    .result_in(result_in), .data_in(data_in), .pc_in(pc_in),
    .mem(mem_bus.master),
    .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_result(wb_result), .wb_rdata(wb_rdata),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int   compared = 0, mismatched = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  // Architectural MEM/WB and sticky-flag state of the reference model
  logic [4:0]  m_rd = '0;
  logic        m_rw = 1'b0, m_mtr = 1'b0, m_terr = 1'b0, m_merr = 1'b0;
  logic [63:0] m_res = '0, m_rdata = '0;

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input op_t o);
    exp_t e;
    bit   is_mem, mis;
    is_mem  = o.mr | o.mw;
    mis     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis     = is_mem && (o.res[2:0] != 3'b000);
`endif
    e.pcsrc = o.br & o.z;
    e.pc    = o.pc;
    e.we    = o.mw & ~o.mr;
    e.addr  = o.res;
    e.wdata = o.data;
    e.stalls = 0;
    e.reqs   = 0;
    if (!is_mem) begin
      m_rd = o.rd; m_rw = o.rw; m_mtr = o.mtr; m_res = o.res;
    end else if (mis) begin
      m_rw = 1'b0; m_mtr = 1'b0; m_merr = 1'b1;
    end else if (o.d >= 1 && o.d <= TO) begin
      e.stalls = o.d;
      e.reqs   = o.d;
      m_rd = o.rd; m_rw = o.rw & o.mr; m_mtr = o.mtr; m_res = o.res;
      if (o.mr) m_rdata = o.ackd;
    end else begin
      e.stalls = TO;
      e.reqs   = TO;
      m_rw = 1'b0; m_mtr = 1'b0; m_terr = 1'b1;
    end
    e.rd = m_rd; e.rw = m_rw; e.mtr = m_mtr; e.result = m_res; e.rdata = m_rdata;
    e.terr = m_terr; e.merr = m_merr;
    return e;
  endfunction

  // Presents one EX/MEM op and plays the memory side until the stage stops stalling.
  task automatic run_op(input op_t o);
    int   idx;
    logic s;
    #1;
    rd_in = o.rd; regwrite_in = o.rw; memtoreg_in = o.mtr;
    memread_in = o.mr; memwrite_in = o.mw; branch_in = o.br; zero_in = o.z;
    result_in = o.res; data_in = o.data; pc_in = o.pc;
    mem_bus.mem_ack   = o.stray;
    mem_bus.mem_rdata = rand64();
    sb.push_back(model(o));
    idx = 0;
    forever begin
      @(negedge clk); s = stall;
      @(posedge clk);
      if (!s) break;
      idx++;
      if (idx > TO + 4) begin
        compared++; mismatched++;
        $display("FAIL stall_bound: stall still high after %0d cycles, limit %0d", idx, TO + 4);
        break;
      end
      #1;
      mem_bus.mem_ack   = (o.mr | o.mw) && (idx == o.d);
      mem_bus.mem_rdata = (idx == o.d) ? o.ackd : rand64();
    end
  endtask

  // Monitor: accumulates per-op behaviour, checks MEM/WB the cycle after the op retires.
  initial begin
    exp_t e;
    int   st_cnt, rq_cnt;
    bit   pend, bus_bad, br_bad;
    st_cnt = 0; rq_cnt = 0; pend = 0; bus_bad = 0; br_bad = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        st_cnt = 0; rq_cnt = 0; pend = 0; bus_bad = 0; br_bad = 0;
        continue;
      end
      if (pend) begin
        e = sb.pop_front();
        chk("stall_cycles", 64'(st_cnt), 64'(e.stalls));
        chk("req_cycles",   64'(rq_cnt), 64'(e.reqs));
        chk("bus_hold_err", 64'(bus_bad), 64'(0));
        chk("branch_err",   64'(br_bad), 64'(0));
        chk("wb_rd",        64'(wb_rd), 64'(e.rd));
        chk("wb_regwrite",  64'(wb_regwrite), 64'(e.rw));
        chk("wb_memtoreg",  64'(wb_memtoreg), 64'(e.mtr));
        chk("wb_result",    wb_result, e.result);
        chk("wb_rdata",     wb_rdata, e.rdata);
        chk("timeout_err",  64'(timeout_err), 64'(e.terr));
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign_err", 64'(misalign_err), 64'(e.merr));
`endif
        pend = 0; st_cnt = 0; rq_cnt = 0; bus_bad = 0; br_bad = 0;
      end
      if (sb.size() == 0) continue;
      e = sb[0];
      if (pcsrc !== e.pcsrc || branch_target !== e.pc) br_bad = 1;
      if (mem_bus.mem_req === 1'b1) begin
        rq_cnt++;
        if (mem_bus.mem_we !== e.we || mem_bus.mem_addr !== e.addr ||
            (e.we && mem_bus.mem_wdata !== e.wdata)) bus_bad = 1;
      end
      if (stall === 1'b1) st_cnt++;
      else pend = 1;
    end
  end

  initial begin
    #1_000_000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    int  k;
    rd_in = '0; regwrite_in = 0; memtoreg_in = 0; memread_in = 0; memwrite_in = 0;
    branch_in = 0; zero_in = 0; result_in = '0; data_in = '0; pc_in = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req",     64'(mem_bus.mem_req), 64'(0));
    chk("rst_mem_we",      64'(mem_bus.mem_we), 64'(0));
    chk("rst_mem_addr",    mem_bus.mem_addr, 64'(0));
    chk("rst_mem_wdata",   mem_bus.mem_wdata, 64'(0));
    chk("rst_wb_rd",       64'(wb_rd), 64'(0));
    chk("rst_wb_regwrite", 64'(wb_regwrite), 64'(0));
    chk("rst_wb_memtoreg", 64'(wb_memtoreg), 64'(0));
    chk("rst_wb_result",   wb_result, 64'(0));
    chk("rst_wb_rdata",    wb_rdata, 64'(0));
    chk("rst_timeout_err", 64'(timeout_err), 64'(0));
    chk("rst_stall",       64'(stall), 64'(0));
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;

    // Directed: ALU, load with late ack, store with immediate ack, timeout, branch, ack on last cycle
    o = '{default: 0}; o.rd = 5'd5; o.rw = 1; o.res = 64'h2A;                  run_op(o);
    o = '{default: 0}; o.rd = 5'd7; o.rw = 1; o.mtr = 1; o.mr = 1;
    o.res = 64'h100; o.d = 3; o.ackd = 64'hDEAD;                               run_op(o);
    o = '{default: 0}; o.rd = 5'd3; o.mw = 1; o.res = 64'h40; o.data = 64'h77;
    o.d = 1;                                                                   run_op(o);
    o = '{default: 0}; o.rd = 5'd9; o.rw = 1; o.mtr = 1; o.mr = 1;
    o.res = 64'h180; o.d = 0;                                                  run_op(o);
    o = '{default: 0}; o.rd = 5'd1; o.br = 1; o.z = 1; o.pc = 64'h80;           run_op(o);
    o = '{default: 0}; o.rd = 5'd4; o.rw = 1; o.mtr = 1; o.mr = 1;
    o.res = 64'h208; o.d = TO; o.ackd = 64'h1234;                              run_op(o);
`ifdef MEM_ALIGN_CHECK_EN
    o = '{default: 0}; o.rd = 5'd6; o.rw = 1; o.mtr = 1; o.mr = 1;
    o.res = 64'h103; o.d = 1;                                                  run_op(o);
`endif

    for (int n = 0; n < 150; n++) begin
      o = '{default: 0};
      o.rd = 5'($urandom()); o.rw = 1'($urandom()); o.mtr = 1'($urandom());
      o.br = 1'($urandom()); o.z = 1'($urandom());
      o.pc = rand64(); o.data = rand64(); o.res = rand64(); o.ackd = rand64();
      o.stray = ($urandom_range(3) == 0);
      k = int'($urandom_range(99));
      if (k >= 50 && k < 75)      o.mr = 1;
      else if (k >= 75 && k < 95) o.mw = 1;
      else if (k >= 95)           begin o.mr = 1; o.mw = 1; end
      if ((o.mr | o.mw) && $urandom_range(4) != 0) o.res[2:0] = 3'b000;
      k = int'($urandom_range(9));
      o.d = (k < 7) ? int'($urandom_range(5, 1)) : ((k == 7) ? TO : 0);
      run_op(o);
    end

    #1;
    rd_in = '0; regwrite_in = 0; memtoreg_in = 0; memread_in = 0; memwrite_in = 0;
    branch_in = 0; zero_in = 0; result_in = '0; data_in = '0; pc_in = '0;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("sb_drain", 64'(sb.size()), 64'(0));
    mon_en = 1'b0;

    // Reset in the middle of a WAIT, then a stray ack
    @(posedge clk); #1;
    memread_in = 1; result_in = 64'h200; rd_in = 5'd9; regwrite_in = 1; memtoreg_in = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_wait_req", 64'(mem_bus.mem_req), 64'(1));
    reset = 1'b0;
    #1;
    chk("rst_wait_req",      64'(mem_bus.mem_req), 64'(0));
    chk("rst_wait_addr",     mem_bus.mem_addr, 64'(0));
    chk("rst_wait_wb_rd",    64'(wb_rd), 64'(0));
    chk("rst_wait_wb_rw",    64'(wb_regwrite), 64'(0));
    chk("rst_wait_wb_res",   wb_result, 64'(0));
    chk("rst_wait_terr",     64'(timeout_err), 64'(0));
    memread_in = 0; result_in = '0; rd_in = '0; regwrite_in = 0; memtoreg_in = 0;
    @(negedge clk) reset = 1'b1;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 64'hBAD;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_req",      64'(mem_bus.mem_req), 64'(0));
    chk("stray_stall",    64'(stall), 64'(0));
    chk("stray_wb_rd",    64'(wb_rd), 64'(0));
    chk("stray_wb_rdata", wb_rdata, 64'(0));
    chk("stray_wb_rw",    64'(wb_regwrite), 64'(0));
    chk("stray_terr",     64'(timeout_err), 64'(0));
    mem_bus.mem_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum WAIT cycles before a memory access is aborted.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 rd_in  in  5, regwrite_in / memtoreg_in / memread_in / memwrite_in / branch_in / zero_in  in  1 each: the EX/MEM register outputs.
REQ-005 result_in  in  64  ALU result, used as memory address; data_in  in  64  store data; pc_in  in  64  branch target.
REQ-006 mem_req  out  1 (load/store request), mem_we  out  1, mem_addr  out  64, mem_wdata  out  64.
REQ-007 mem_ack  in  1  completion strobe; mem_rdata  in  64  load data, valid while mem_ack=1.
REQ-008 stall  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-009 pcsrc  out  1 and branch_target  out  64: redirect to the fetch stage.
REQ-010 wb_rd  out  5, wb_regwrite / wb_memtoreg  out  1, wb_result / wb_rdata  out  64: MEM/WB register.
REQ-011 timeout_err  out  1  sticky flag: an access was aborted.

Function
REQ-012 FSM states: IDLE, WAIT.
- IDLE->WAIT at the clock edge when memread_in|memwrite_in.
- WAIT->IDLE on mem_ack or on timeout.
REQ-013 mem_req=1 only in WAIT.
- mem_we, mem_addr and mem_wdata are registered on IDLE->WAIT and held constant throughout WAIT.
- mem_we=memwrite_in; memread_in has priority if both are set (treated as a load, mem_we=0).
REQ-014 stall=1 (combinational) when (IDLE and memread_in|memwrite_in) or (WAIT and !mem_ack and !timeout).
- Minimum load/store penalty: exactly 1 stall cycle.
REQ-015 Non-memory op in IDLE: the wb_* registers capture rd_in, regwrite_in, memtoreg_in and result_in next edge (1-cycle latency); wb_rdata holds its value.
REQ-016 Memory op: on the mem_ack edge in WAIT, wb_* capture the held control/rd/result and wb_rdata<=mem_rdata (loads); stores write wb_regwrite=0.
REQ-017 Every edge where stall=1: wb_regwrite<=0 and wb_memtoreg<=0 (bubble inserted).
REQ-018 WAIT counter counts from 0 each entry.
- Reaching TIMEOUT-1 without ack: abort, return to IDLE, set timeout_err=1, write a bubble to wb_*, release stall that cycle.
REQ-019 mem_ack outside WAIT is ignored.
- mem_ack on the timeout cycle counts as a normal completion (no error).
REQ-020 pcsrc=branch_in&zero_in, branch_target=pc_in; both combinational, unaffected by the FSM.
REQ-021 timeout_err clears only on reset.

Reset
REQ-022 reset=0 immediately forces: state IDLE, mem_req=0, mem_we=0, counter=0, timeout_err=0, all wb_* outputs=0, mem_addr=0, mem_wdata=0.
REQ-023 Reset during WAIT abandons the access; no write-back occurs; any later ack is ignored.

Configuration
REQ-024 Macro MEM_ALIGN_CHECK_EN, when defined:
- A memory op with result_in[2:0]!=0 does not enter WAIT.
- Sticky output misalign_err (1-bit) is set.
- A bubble is written; stall=0 for that op.
REQ-025 When MEM_ALIGN_CHECK_EN is undefined:
- misalign_err is absent.
- The address is passed through unchecked.

Structure
REQ-026 Package mem_stage_pkg SHALL hold the state enum (IDLE, WAIT), XLEN=64, REGADDR_W=5 and the TIMEOUT default.
REQ-027 One sub-module, mem_timeout_ctr (load/enable/expire counter); all else in mem_access_stage.

Verification
REQ-028 ALU op: regwrite_in=1, rd_in=5, result_in=0x2A -> stall=0; next edge wb_rd=5, wb_result=0x2A, wb_regwrite=1.
REQ-029 Load addr 0x100, mem_ack after 3 WAIT cycles with rdata 0xDEAD -> stall high 3 cycles, mem_req high 3 cycles, then wb_rdata=0xDEAD, wb_memtoreg=1.
REQ-030 Store addr 0x40, data 0x77, ack on the first WAIT cycle -> mem_we=1, mem_wdata=0x77, 1 stall cycle, wb_regwrite=0.
REQ-031 Load, no ack, TIMEOUT=16 -> mem_req high exactly 16 cycles, timeout_err=1, stall released, bubble written.
REQ-032 reset=0 mid-WAIT, then stray mem_ack -> mem_req=0 at once, state IDLE, no wb update.
REQ-033 branch_in=1, zero_in=1, pc_in=0x80 -> pcsrc=1, branch_target=0x80 in the same cycle; with MEM_ALIGN_CHECK_EN, load addr 0x103 -> misalign_err=1, no mem_req.
